// File: rtl/run_detect_if.sv
// Sample/detect bundle between a bit source and run_detect.
// The master drives the sample controls, the slave returns the detect state.
interface run_detect_if #(
   parameter int RUN_LEN = 2,
   parameter int CNT_W   = 8
);
   localparam int RCW = $clog2(RUN_LEN + 1);

   logic             en;
   logic             w;
   logic             mode;
   logic             hit_clr;
   logic             z;
   logic [RCW-1:0]   run_cnt;
   logic [CNT_W-1:0] hit_cnt;
   logic             hit_ovf;

   modport master (
      output en, w, mode, hit_clr,
      input  z, run_cnt, hit_cnt, hit_ovf
   );

   modport slave (
      input  en, w, mode, hit_clr,
      output z, run_cnt, hit_cnt, hit_ovf
   );
endinterface

// File: rtl/run_detect.sv
// Consecutive-ones run detector with level/pulse output and hit counter.
// Hit counter is built only when RUN_DETECT_HIT_CNT_EN is defined.
module run_detect #(
   parameter int RUN_LEN = 2,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   run_detect_if.slave bus
);
   localparam int RCW = $clog2(RUN_LEN + 1);
   localparam logic [RCW-1:0] RUN_MAX = RCW'(RUN_LEN);

   logic [RCW-1:0] run_cnt_q, run_cnt_d;
   logic           z_q, z_d;
   logic [31:0]    run_nxt;
   logic           pre;

   // Widened so run_cnt + 1 never wraps at the top of the range.
   assign run_nxt = 32'(run_cnt_q) + 32'd1;
   assign pre     = bus.en && bus.w && (run_nxt >= 32'(RUN_LEN));

   always_comb begin
      run_cnt_d = run_cnt_q;
      z_d       = 1'b0;
      if (bus.en) begin
         if (!bus.w) begin
            run_cnt_d = '0;
         end else if (bus.mode) begin
            if (pre) begin
               run_cnt_d = '0;
               z_d       = 1'b1;
            end else begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end else begin
            z_d = pre;
            if (run_cnt_q != RUN_MAX) begin
               run_cnt_d = run_cnt_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         run_cnt_q <= '0;
         z_q       <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         z_q       <= z_d;
      end
   end

   assign bus.z       = z_q;
   assign bus.run_cnt = run_cnt_q;

`ifdef RUN_DETECT_HIT_CNT_EN
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic             hit_ovf_q, hit_ovf_d;
   logic             hit;

   // Level mode counts a run once: no hit while already saturated.
   assign hit = pre && (bus.mode || (run_cnt_q != RUN_MAX));

   always_comb begin
      hit_cnt_d = hit_cnt_q;
      hit_ovf_d = hit_ovf_q;
      if (bus.hit_clr) begin
         hit_cnt_d = '0;
         hit_ovf_d = 1'b0;
      end else if (hit) begin
         if (&hit_cnt_q) begin
            hit_ovf_d = 1'b1;
         end else begin
            hit_cnt_d = hit_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hit_cnt_q <= '0;
         hit_ovf_q <= 1'b0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         hit_ovf_q <= hit_ovf_d;
      end
   end

   assign bus.hit_cnt = hit_cnt_q;
   assign bus.hit_ovf = hit_ovf_q;
`else
   assign bus.hit_cnt = '0;
   assign bus.hit_ovf = 1'b0;
`endif
endmodule
